// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//   Definitions shared by the tank-game match logic.
//   - match_state_t  : 3-bit match sequencer state encoding.
//   - WINNER_*       : 2-bit codes for the HUD winner field.
//   - *_DEF          : default frame timing (60 Hz video assumed).
// ---------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      COUNTDOWN  = 3'd1,
      PLAYING    = 3'd2,
      ROUND_OVER = 3'd3,
      MATCH_OVER = 3'd4
   } match_state_t;

   localparam logic [1:0] WINNER_NONE = 2'd0;
   localparam logic [1:0] WINNER_P1   = 2'd1;
   localparam logic [1:0] WINNER_P2   = 2'd2;

   localparam int FRAMES_PER_STEP_DEF = 60;
   localparam int OVER_FRAMES_DEF     = 120;

endpackage

// File: rtl/frame_timer.sv
// ---------------------------------------------------------------------------
// frame_timer
//   Counts frame_tick pulses while enabled and flags the tick that completes
//   a run of `limit` ticks.  The count then restarts from 0.
//
//   clk    in   system clock
//   reset  in   synchronous active-high, clears the count
//   load   in   synchronous restart of the count at 0 (wins over tick)
//   en     in   count ticks only while high
//   tick   in   one-cycle frame pulse
//   limit  in   number of ticks per completed run (>= 1)
//   done   out  high in the cycle of the limit-th tick
//
//   done is combinational so the owner can act on it in the same cycle; it
//   deliberately does not depend on load, since the owner drives load from
//   done when a run completion causes a state change.
// ---------------------------------------------------------------------------
module frame_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic             tick,
   input  logic [CNT_W-1:0] limit,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;

   assign done = en & tick & (cnt_q == (limit - CNT_W'(1)));

   always_ff @(posedge clk) begin
      if (reset || load) begin
         cnt_q <= '0;
      end else if (en && tick) begin
         cnt_q <= done ? '0 : cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/match_ctrl.sv
// ---------------------------------------------------------------------------
// match_ctrl
//   Match-level sequencer for the tank game: countdown, play, round-end hold
//   and match-end, with per-player round scores and the match winner.
//
//   Optional macro MATCH_PAUSE_EN adds pause_btn / paused.
//
//   clk           in   system clock
//   reset         in   synchronous active-high, returns to IDLE
//   start         in   debounced button level, 0->1 edge acts
//   frame_tick    in   one-cycle pulse per video frame
//   hit_player    in   player 1 was hit (may stay high)
//   hit_opponent  in   player 2 was hit (may stay high)
//   pause_btn     in   (MATCH_PAUSE_EN) pause button level
//   engine_reset  out  reset to the game engine
//   game_on       out  high only while actively playing
//   score1/score2 out  rounds won by player 1 / player 2
//   winner        out  0 none, 1 player 1, 2 player 2
//   countdown     out  remaining countdown step, 0 outside COUNTDOWN
//   state         out  current state encoding
//   round_done    out  one-cycle pulse on entry to ROUND_OVER
//   paused        out  (MATCH_PAUSE_EN) play is paused
//
//   Every output is a register loaded from the next-state values, so a
//   condition seen at edge N is visible right after edge N.
// ---------------------------------------------------------------------------
module match_ctrl
   import game_pkg::*;
#(
   parameter int WIN_SCORE       = 3,
   parameter int FRAMES_PER_STEP = FRAMES_PER_STEP_DEF,
   parameter int COUNT_STEPS     = 3,
   parameter int OVER_FRAMES     = OVER_FRAMES_DEF,
   parameter int SCORE_W         = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               frame_tick,
   input  logic               hit_player,
   input  logic               hit_opponent,
`ifdef MATCH_PAUSE_EN
   input  logic               pause_btn,
   output logic               paused,
`endif
   output logic               engine_reset,
   output logic               game_on,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [1:0]         winner,
   output logic [1:0]         countdown,
   output logic [2:0]         state,
   output logic               round_done
);

   localparam logic [2:0] S_IDLE       = IDLE;
   localparam logic [2:0] S_COUNTDOWN  = COUNTDOWN;
   localparam logic [2:0] S_PLAYING    = PLAYING;
   localparam logic [2:0] S_ROUND_OVER = ROUND_OVER;
   localparam logic [2:0] S_MATCH_OVER = MATCH_OVER;

   localparam int TMAX  = (FRAMES_PER_STEP > OVER_FRAMES) ? FRAMES_PER_STEP : OVER_FRAMES;
   localparam int CNT_W = $clog2(TMAX + 1);

   localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);
   localparam logic [1:0]         STEPS = 2'(COUNT_STEPS);

   logic [2:0]         state_q, state_d;
   logic [1:0]         step_q, step_d;
   logic [SCORE_W-1:0] score1_q, score1_d;
   logic [SCORE_W-1:0] score2_q, score2_d;
   logic [1:0]         winner_q, winner_d;
   logic               start_q;
   logic               engine_reset_q, game_on_q, round_done_q;
   logic [1:0]         countdown_q;
   logic               paused_d;
   logic               hold_play;

   logic               tmr_load, tmr_en, tmr_done;
   logic [CNT_W-1:0]   tmr_limit;

   logic start_edge;
   assign start_edge = start & ~start_q;

   // Sampled every cycle, including during reset: a button held down
   // through reset must not look like a fresh press afterwards.
   always_ff @(posedge clk) begin
      start_q <= start;
   end

`ifdef MATCH_PAUSE_EN
   logic pause_q, paused_q;

   always_ff @(posedge clk) begin
      pause_q <= pause_btn;
   end

   always_comb begin
      paused_d = paused_q;
      if (state_d != S_PLAYING) begin
         paused_d = 1'b0;
      end else if (state_q == S_PLAYING && pause_btn && !pause_q) begin
         paused_d = ~paused_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) paused_q <= 1'b0;
      else       paused_q <= paused_d;
   end

   assign hold_play = paused_q;
   assign paused    = paused_q;
`else
   assign paused_d  = 1'b0;
   assign hold_play = 1'b0;
`endif

   // One timer serves both the countdown steps and the round-over hold.
   assign tmr_limit = (state_q == S_ROUND_OVER) ? CNT_W'(OVER_FRAMES)
                                                : CNT_W'(FRAMES_PER_STEP);

   frame_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (tmr_load),
      .en    (tmr_en),
      .tick  (frame_tick),
      .limit (tmr_limit),
      .done  (tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      score1_d = score1_q;
      score2_d = score2_q;
      winner_d = winner_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      case (state_q)
         S_IDLE, S_MATCH_OVER: begin
            if (start_edge) begin
               score1_d = '0;
               score2_d = '0;
               winner_d = WINNER_NONE;
               step_d   = STEPS;
               tmr_load = 1'b1;
               state_d  = S_COUNTDOWN;
            end
         end
         S_COUNTDOWN: begin
            tmr_en = 1'b1;
            if (tmr_done) begin
               step_d = step_q - 2'd1;
               if (step_q == 2'd1) begin
                  tmr_load = 1'b1;
                  state_d  = S_PLAYING;
               end
            end
         end
         S_PLAYING: begin
            // Any hit ends the round; a simultaneous double hit is a draw.
            if ((hit_player || hit_opponent) && !hold_play) begin
               if (hit_opponent && !hit_player && score1_q != WIN)
                  score1_d = score1_q + SCORE_W'(1);
               if (hit_player && !hit_opponent && score2_q != WIN)
                  score2_d = score2_q + SCORE_W'(1);
               tmr_load = 1'b1;
               state_d  = S_ROUND_OVER;
            end
         end
         S_ROUND_OVER: begin
            tmr_en = 1'b1;
            if (tmr_done) begin
               tmr_load = 1'b1;
               if (score1_q == WIN) begin
                  winner_d = WINNER_P1;
                  state_d  = S_MATCH_OVER;
               end else if (score2_q == WIN) begin
                  winner_d = WINNER_P2;
                  state_d  = S_MATCH_OVER;
               end else begin
                  step_d  = STEPS;
                  state_d = S_COUNTDOWN;
               end
            end
         end
         default: begin
            tmr_load = 1'b1;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         step_q         <= '0;
         score1_q       <= '0;
         score2_q       <= '0;
         winner_q       <= WINNER_NONE;
         engine_reset_q <= 1'b1;
         game_on_q      <= 1'b0;
         countdown_q    <= '0;
         round_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         step_q         <= step_d;
         score1_q       <= score1_d;
         score2_q       <= score2_d;
         winner_q       <= winner_d;
         engine_reset_q <= (state_d == S_IDLE) || (state_d == S_COUNTDOWN);
         game_on_q      <= (state_d == S_PLAYING) && !paused_d;
         countdown_q    <= (state_d == S_COUNTDOWN) ? step_d : 2'd0;
         round_done_q   <= (state_d == S_ROUND_OVER) && (state_q != S_ROUND_OVER);
      end
   end

   assign state        = state_q;
   assign score1       = score1_q;
   assign score2       = score2_q;
   assign winner       = winner_q;
   assign engine_reset = engine_reset_q;
   assign game_on      = game_on_q;
   assign countdown    = countdown_q;
   assign round_done   = round_done_q;

endmodule

// File: tb/tb_match_ctrl.sv
// ---------------------------------------------------------------------------
// tb_match_ctrl
//   Self-checking bench for match_ctrl with FRAMES_PER_STEP=2, COUNT_STEPS=3,
//   OVER_FRAMES=4, WIN_SCORE=2.  Expected score pairs are queued when a hit
//   is driven and checked when round_done appears.
// ---------------------------------------------------------------------------
module tb_match_ctrl;

   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          reset, start, frame_tick, hit_player, hit_opponent;
   logic          engine_reset, game_on, round_done;
   logic [SW-1:0] score1, score2;
   logic [1:0]    winner, countdown;
   logic [2:0]    state;
`ifdef MATCH_PAUSE_EN
   logic          pause_btn, paused;
`endif

   int errs = 0;
   int checks = 0;
   int rd_cnt = 0;

   typedef struct { int s1; int s2; } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   match_ctrl #(
      .WIN_SCORE(2), .FRAMES_PER_STEP(2), .COUNT_STEPS(3),
      .OVER_FRAMES(4), .SCORE_W(SW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .frame_tick   (frame_tick),
      .hit_player   (hit_player),
      .hit_opponent (hit_opponent),
`ifdef MATCH_PAUSE_EN
      .pause_btn    (pause_btn),
      .paused       (paused),
`endif
      .engine_reset (engine_reset),
      .game_on      (game_on),
      .score1       (score1),
      .score2       (score2),
      .winner       (winner),
      .countdown    (countdown),
      .state        (state),
      .round_done   (round_done)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         cyc();
         frame_tick = 1'b0;
         cyc();
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   // Scoreboard consumer: every round_done must match a queued score pair.
   always @(negedge clk) begin
      if (round_done) begin
         rd_cnt++;
         chk("sb_avail", int'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_score1", int'(score1), e.s1);
            chk("sb_score2", int'(score2), e.s2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int rd0;
      reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
      hit_player = 1'b0; hit_opponent = 1'b0;
`ifdef MATCH_PAUSE_EN
      pause_btn = 1'b0;
`endif
      cyc(); cyc();
      reset = 1'b0;

      // reset state
      chk("rst_state", state, 0);
      chk("rst_eng_reset", engine_reset, 1);
      chk("rst_game_on", game_on, 0);
      chk("rst_score1", score1, 0);
      chk("rst_score2", score2, 0);
      chk("rst_winner", winner, 0);
      chk("rst_countdown", countdown, 0);
      chk("rst_round_done", round_done, 0);

      // 1: countdown sequence
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("t1_state_cd", state, 1);
      chk("t1_cd3", countdown, 3);
      chk("t1_eng_reset", engine_reset, 1);
      cyc();
      frames(2);
      chk("t1_cd2", countdown, 2);
      frames(1);
      chk("t1_cd2_mid", countdown, 2);
      frames(1);
      chk("t1_cd1", countdown, 1);
      frames(2);
      chk("t1_state_play", state, 2);
      chk("t1_game_on", game_on, 1);
      chk("t1_eng_reset0", engine_reset, 0);
      chk("t1_cd0", countdown, 0);
      pulse_start();
      chk("t1_start_ignored", state, 2);

      // 2: held hit scores once
      rd0 = rd_cnt;
      sb.push_back('{1, 0});
      hit_opponent = 1'b1;
      repeat (10) cyc();
      hit_opponent = 1'b0;
      chk("t2_state_ro", state, 3);
      chk("t2_score1", score1, 1);
      chk("t2_rd_pulses", rd_cnt - rd0, 1);
      chk("t2_game_on", game_on, 0);
      chk("t2_eng_reset", engine_reset, 0);
      frames(3);
      chk("t2_hold", state, 3);
      frames(1);
      chk("t2_state_cd", state, 1);
      chk("t2_eng_reset1", engine_reset, 1);
      chk("t2_cd3", countdown, 3);
      frames(6);
      chk("t2_replay", state, 2);

      // 3: draw
      sb.push_back('{1, 0});
      hit_player = 1'b1; hit_opponent = 1'b1;
      cyc();
      hit_player = 1'b0; hit_opponent = 1'b0;
      chk("t3_state_ro", state, 3);
      chk("t3_score2", score2, 0);
      frames(4);
      chk("t3_state_cd", state, 1);
      frames(6);

      // 4: player 1 wins the match
      sb.push_back('{2, 0});
      hit_opponent = 1'b1;
      cyc();
      hit_opponent = 1'b0;
      chk("t4_score1", score1, 2);
      frames(4);
      chk("t4_state_mo", state, 4);
      chk("t4_winner", winner, 1);
      chk("t4_game_on", game_on, 0);
      chk("t4_eng_reset", engine_reset, 0);
      pulse_start();
      chk("t4_restart_state", state, 1);
      chk("t4_restart_score1", score1, 0);
      chk("t4_restart_winner", winner, 0);

      // 5: reset during COUNTDOWN and ROUND_OVER
      frames(1);
      do_reset();
      chk("t5a_state", state, 0);
      chk("t5a_eng_reset", engine_reset, 1);
      chk("t5a_countdown", countdown, 0);
      cyc();
      pulse_start();
      frames(6);
      sb.push_back('{0, 1});
      hit_player = 1'b1;
      cyc();
      hit_player = 1'b0;
      chk("t5b_score2", score2, 1);
      frames(2);
      do_reset();
      chk("t5b_state", state, 0);
      chk("t5b_score2", score2, 0);
      chk("t5b_eng_reset", engine_reset, 1);
      start = 1'b1;
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      cyc(); cyc(); cyc();
      chk("t5c_held_start", state, 0);
      start = 1'b0;
      cyc();

`ifdef MATCH_PAUSE_EN
      // 6: pause
      pulse_start();
      frames(6);
      chk("t6_play", state, 2);
      pause_btn = 1'b1;
      cyc();
      chk("t6_paused", paused, 1);
      chk("t6_game_on0", game_on, 0);
      hit_opponent = 1'b1;
      cyc(); cyc();
      hit_opponent = 1'b0;
      chk("t6_score1", score1, 0);
      chk("t6_still_play", state, 2);
      pause_btn = 1'b0;
      cyc();
      pause_btn = 1'b1;
      cyc();
      chk("t6_unpaused", paused, 0);
      chk("t6_game_on1", game_on, 1);
      pause_btn = 1'b0;
      cyc();
`endif

      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
